// File: rtl/reu_dma_sequencer.sv
// REU DMA sequencer: stash/fetch/swap/verify between the C64 bus and expansion RAM.
// One byte per BA-high PHI2 cycle (swap takes two); BA low freezes all progress.
module reu_dma_sequencer #(
  parameter int REU_AW = 19
) (
  input  logic              PHI2,
  input  logic              nRES,
  input  logic              Execute,
  input  logic [1:0]        Cmd,
  input  logic              Autoload,
  input  logic              FixC64,
  input  logic              FixREU,
  input  logic [15:0]       C64Base,
  input  logic [REU_AW-1:0] REUBase,
  input  logic [15:0]       LenBase,
  input  logic              BA,
  input  logic [7:0]        C64Din,
  input  logic [7:0]        RAMDin,
  output logic              DMA,
  output logic              DMARW,
  output logic [15:0]       C64A,
  output logic [REU_AW-1:0] REUA,
  output logic [7:0]        C64Dout,
  output logic [7:0]        RAMDout,
  output logic              RAMWE,
  output logic              Busy,
  output logic              Done,
  output logic              EOB,
  output logic              Fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_XFER, S_SWAP_RD, S_SWAP_WR, S_FINISH
  } state_t;

  localparam logic [1:0] CMD_STASH  = 2'b00;
  localparam logic [1:0] CMD_FETCH  = 2'b01;
  localparam logic [1:0] CMD_SWAP   = 2'b10;
  localparam logic [1:0] CMD_VERIFY = 2'b11;
  localparam logic [REU_AW-1:0] REU_ONE = REU_AW'(1);

  state_t            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [15:0]       c64a_q, c64a_d;
  logic [REU_AW-1:0] reua_q, reua_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hc_q, hc_d, hr_q, hr_d;
  logic              dma_q, dma_d, busy_q, busy_d;
  logic              done_q, done_d, eob_q, eob_d, fault_q, fault_d;
  logic              step, last, mismatch;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    c64a_d   = c64a_q;
    reua_d   = reua_q;
    len_d    = len_q;
    hc_d     = hc_q;
    hr_d     = hr_q;
    dma_d    = dma_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    eob_d    = 1'b0;
    fault_d  = 1'b0;
    step     = 1'b0;
    last     = (len_q == 16'd1);
    mismatch = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Execute) begin
          cmd_d   = Cmd;
          c64a_d  = C64Base;
          reua_d  = REUBase;
          len_d   = LenBase;
          dma_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = (Cmd == CMD_SWAP) ? S_SWAP_RD : S_XFER;
        end
      end
      S_XFER: begin
        if (BA) begin
          step     = 1'b1;
          mismatch = (cmd_q == CMD_VERIFY) && (C64Din != RAMDin);
          if (last || mismatch) begin
            state_d = S_FINISH;
            dma_d   = 1'b0;
            done_d  = 1'b1;
            eob_d   = last;
            fault_d = mismatch;
          end
        end
      end
      S_SWAP_RD: begin
        if (BA) begin
          hc_d    = C64Din;
          hr_d    = RAMDin;
          state_d = S_SWAP_WR;
        end
      end
      S_SWAP_WR: begin
        if (BA) begin
          step = 1'b1;
          if (last) begin
            state_d = S_FINISH;
            dma_d   = 1'b0;
            done_d  = 1'b1;
            eob_d   = 1'b1;
          end else begin
            state_d = S_SWAP_RD;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (Autoload) begin
          c64a_d = C64Base;
          reua_d = REUBase;
          len_d  = LenBase;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Counters still step past a failing verify byte, like the original REC.
    if (step) begin
      if (!FixC64) c64a_d = c64a_q + 16'd1;
      if (!FixREU) reua_d = reua_q + REU_ONE;
      len_d = len_q - 16'd1;
    end
  end

  always_ff @(posedge PHI2) begin
    if (!nRES) begin
      state_q <= S_IDLE;
      cmd_q   <= CMD_STASH;
      c64a_q  <= C64Base;
      reua_q  <= REUBase;
      len_q   <= LenBase;
      hc_q    <= 8'h00;
      hr_q    <= 8'h00;
      dma_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eob_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      c64a_q  <= c64a_d;
      reua_q  <= reua_d;
      len_q   <= len_d;
      hc_q    <= hc_d;
      hr_q    <= hr_d;
      dma_q   <= dma_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eob_q   <= eob_d;
      fault_q <= fault_d;
    end
  end

  assign DMA     = dma_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign EOB     = eob_q;
  assign Fault   = fault_q;
  assign C64A    = c64a_q;
  assign REUA    = reua_q;
  assign DMARW   = !((state_q == S_SWAP_WR) || (state_q == S_XFER && cmd_q == CMD_FETCH));
  assign RAMWE   = BA && ((state_q == S_SWAP_WR) || (state_q == S_XFER && cmd_q == CMD_STASH));
  assign C64Dout = (state_q == S_SWAP_WR) ? hr_q : RAMDin;
  assign RAMDout = (state_q == S_SWAP_WR) ? hc_q : C64Din;

endmodule

// File: tb/tb_reu_dma_sequencer.sv
// Directed, table-driven bench for reu_dma_sequencer plus hand sequences for
// restart/reset behaviour and a full 65536-byte fixed-address autoload transfer.
module tb_reu_dma_sequencer;

  logic        PHI2 = 1'b0;
  logic        nRES, Execute, Autoload, FixC64, FixREU, BA;
  logic [1:0]  Cmd;
  logic [15:0] C64Base, LenBase;
  logic [18:0] REUBase;
  logic [7:0]  C64Din, RAMDin;
  logic        DMA, DMARW, RAMWE, Busy, Done, EOB, Fault;
  logic [15:0] C64A;
  logic [18:0] REUA;
  logic [7:0]  C64Dout, RAMDout;

  int errors = 0;
  int checks = 0;

  always #5 PHI2 = ~PHI2;

  reu_dma_sequencer #(.REU_AW(19)) dut (
    .PHI2(PHI2), .nRES(nRES), .Execute(Execute), .Cmd(Cmd), .Autoload(Autoload),
    .FixC64(FixC64), .FixREU(FixREU), .C64Base(C64Base), .REUBase(REUBase),
    .LenBase(LenBase), .BA(BA), .C64Din(C64Din), .RAMDin(RAMDin), .DMA(DMA),
    .DMARW(DMARW), .C64A(C64A), .REUA(REUA), .C64Dout(C64Dout), .RAMDout(RAMDout),
    .RAMWE(RAMWE), .Busy(Busy), .Done(Done), .EOB(EOB), .Fault(Fault)
  );

  typedef struct {
    logic        exe;
    logic [1:0]  cmd;
    logic [15:0] len;
    logic        ba;
    logic [7:0]  cd, rd;
    logic        dma, dmarw, ramwe, busy, done, eob, fault;
    logic [15:0] c64a;
    logic [18:0] reua;
    logic [1:0]  chk;       // bit1: check C64Dout, bit0: check RAMDout
    logic [7:0]  c64dout, ramdout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int exe, int cmd, int len, int ba, int cd, int rd,
                              int dma, int dmarw, int ramwe, int busy, int done,
                              int eob, int fault, int c64a, int reua, int chk,
                              int c64dout, int ramdout);
    vec_t v;
    v.exe = 1'(exe);   v.cmd = 2'(cmd);     v.len = 16'(len);   v.ba = 1'(ba);
    v.cd = 8'(cd);     v.rd = 8'(rd);       v.dma = 1'(dma);    v.dmarw = 1'(dmarw);
    v.ramwe = 1'(ramwe); v.busy = 1'(busy); v.done = 1'(done);  v.eob = 1'(eob);
    v.fault = 1'(fault); v.c64a = 16'(c64a); v.reua = 19'(reua); v.chk = 2'(chk);
    v.c64dout = 8'(c64dout); v.ramdout = 8'(ramdout);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    nRES = 1'b0; Execute = 1'b0; Cmd = 2'b00; Autoload = 1'b0; FixC64 = 1'b0;
    FixREU = 1'b0; BA = 1'b1; C64Base = 16'hC000; REUBase = 19'h0; LenBase = 16'd3;
    C64Din = 8'h00; RAMDin = 8'h00;

    // Stash 3 bytes
    vecs.push_back(mk(1,0,3,1,'h11,0, 0,1,0,0,0,0,0,'hC000,0, 0,0,0));
    vecs.push_back(mk(0,0,3,1,'hA1,0, 1,1,1,1,0,0,0,'hC000,0, 1,0,'hA1));
    vecs.push_back(mk(0,0,3,1,'hA2,0, 1,1,1,1,0,0,0,'hC001,1, 1,0,'hA2));
    vecs.push_back(mk(0,0,3,1,'hA3,0, 1,1,1,1,0,0,0,'hC002,2, 1,0,'hA3));
    vecs.push_back(mk(0,0,3,1,0,0,    0,1,0,1,1,1,0,'hC003,3, 0,0,0));
    vecs.push_back(mk(0,0,3,1,0,0,    0,1,0,0,0,0,0,'hC003,3, 0,0,0));
    // Fetch 4 bytes, BA low for 2 cycles after byte 1
    vecs.push_back(mk(1,1,4,1,0,0,    0,1,0,0,0,0,0,'hC003,3, 0,0,0));
    vecs.push_back(mk(0,1,4,1,0,'hB1, 1,0,0,1,0,0,0,'hC000,0, 2,'hB1,0));
    vecs.push_back(mk(0,1,4,0,0,'hEE, 1,0,0,1,0,0,0,'hC001,1, 0,0,0));
    vecs.push_back(mk(0,1,4,0,0,'hEE, 1,0,0,1,0,0,0,'hC001,1, 0,0,0));
    vecs.push_back(mk(0,1,4,1,0,'hB2, 1,0,0,1,0,0,0,'hC001,1, 2,'hB2,0));
    vecs.push_back(mk(0,1,4,1,0,'hB3, 1,0,0,1,0,0,0,'hC002,2, 2,'hB3,0));
    vecs.push_back(mk(0,1,4,1,0,'hB4, 1,0,0,1,0,0,0,'hC003,3, 2,'hB4,0));
    vecs.push_back(mk(0,1,4,1,0,0,    0,1,0,1,1,1,0,'hC004,4, 0,0,0));
    vecs.push_back(mk(0,1,4,1,0,0,    0,1,0,0,0,0,0,'hC004,4, 0,0,0));
    // Swap 2 bytes: read/write alternate, write data comes from latched reads
    vecs.push_back(mk(1,2,2,1,0,0,       0,1,0,0,0,0,0,'hC004,4, 0,0,0));
    vecs.push_back(mk(0,2,2,1,'hC1,'hD1, 1,1,0,1,0,0,0,'hC000,0, 0,0,0));
    vecs.push_back(mk(0,2,2,1,0,0,       1,0,1,1,0,0,0,'hC000,0, 3,'hD1,'hC1));
    vecs.push_back(mk(0,2,2,1,'hC2,'hD2, 1,1,0,1,0,0,0,'hC001,1, 0,0,0));
    vecs.push_back(mk(0,2,2,1,0,0,       1,0,1,1,0,0,0,'hC001,1, 3,'hD2,'hC2));
    vecs.push_back(mk(0,2,2,1,0,0,       0,1,0,1,1,1,0,'hC002,2, 0,0,0));
    vecs.push_back(mk(0,2,2,1,0,0,       0,1,0,0,0,0,0,'hC002,2, 0,0,0));
    // Verify 5 bytes, mismatch on byte 2
    vecs.push_back(mk(1,3,5,1,0,0,       0,1,0,0,0,0,0,'hC002,2, 0,0,0));
    vecs.push_back(mk(0,3,5,1,'h5A,'h5A, 1,1,0,1,0,0,0,'hC000,0, 0,0,0));
    vecs.push_back(mk(0,3,5,1,'h5B,'h5C, 1,1,0,1,0,0,0,'hC001,1, 0,0,0));
    vecs.push_back(mk(0,3,5,1,0,0,       0,1,0,1,1,0,1,'hC002,2, 0,0,0));
    vecs.push_back(mk(0,3,5,1,0,0,       0,1,0,0,0,0,0,'hC002,2, 0,0,0));

    repeat (2) @(negedge PHI2);
    #1;
    chk("rst.dma", 32'(DMA), 32'd0);
    chk("rst.dmarw", 32'(DMARW), 32'd1);
    chk("rst.ramwe", 32'(RAMWE), 32'd0);
    chk("rst.busy", 32'(Busy), 32'd0);
    chk("rst.done", 32'(Done | EOB | Fault), 32'd0);
    chk("rst.c64a", 32'(C64A), 32'hC000);
    chk("rst.reua", 32'(REUA), 32'h0);
    nRES = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge PHI2);
      Execute = vecs[i].exe; Cmd = vecs[i].cmd; LenBase = vecs[i].len;
      BA = vecs[i].ba; C64Din = vecs[i].cd; RAMDin = vecs[i].rd;
      #1;
      chk($sformatf("v%0d.dma", i),   32'(DMA),   32'(vecs[i].dma));
      chk($sformatf("v%0d.dmarw", i), 32'(DMARW), 32'(vecs[i].dmarw));
      chk($sformatf("v%0d.ramwe", i), 32'(RAMWE), 32'(vecs[i].ramwe));
      chk($sformatf("v%0d.busy", i),  32'(Busy),  32'(vecs[i].busy));
      chk($sformatf("v%0d.done", i),  32'(Done),  32'(vecs[i].done));
      chk($sformatf("v%0d.eob", i),   32'(EOB),   32'(vecs[i].eob));
      chk($sformatf("v%0d.fault", i), 32'(Fault), 32'(vecs[i].fault));
      chk($sformatf("v%0d.c64a", i),  32'(C64A),  32'(vecs[i].c64a));
      chk($sformatf("v%0d.reua", i),  32'(REUA),  32'(vecs[i].reua));
      if (vecs[i].chk[1]) chk($sformatf("v%0d.c64dout", i), 32'(C64Dout), 32'(vecs[i].c64dout));
      if (vecs[i].chk[0]) chk($sformatf("v%0d.ramdout", i), 32'(RAMDout), 32'(vecs[i].ramdout));
    end

    // Execute while busy is ignored; reset mid-transfer aborts without Done
    @(negedge PHI2);
    Execute = 1'b1; Cmd = 2'b00; LenBase = 16'd4; BA = 1'b1;
    @(negedge PHI2);
    Execute = 1'b1; Cmd = 2'b01; LenBase = 16'd2;
    #1;
    chk("busy_exe.c64a0", 32'(C64A), 32'hC000);
    chk("busy_exe.dmarw0", 32'(DMARW), 32'd1);
    @(negedge PHI2);
    Execute = 1'b0;
    #1;
    chk("busy_exe.c64a1", 32'(C64A), 32'hC001);
    chk("busy_exe.dmarw1", 32'(DMARW), 32'd1);
    chk("busy_exe.ramwe1", 32'(RAMWE), 32'd1);
    nRES = 1'b0;
    @(negedge PHI2);
    #1;
    chk("midrst.dma", 32'(DMA), 32'd0);
    chk("midrst.busy", 32'(Busy), 32'd0);
    chk("midrst.ramwe", 32'(RAMWE), 32'd0);
    chk("midrst.done", 32'(Done), 32'd0);
    chk("midrst.c64a", 32'(C64A), 32'hC000);
    nRES = 1'b1;
    @(negedge PHI2);
    #1;
    chk("midrst.done_after", 32'(Done), 32'd0);
    chk("midrst.dma_after", 32'(DMA), 32'd0);

    // 65536-byte stash, C64 address fixed, REU address wraps, autoload on end
    begin
      int wr_cnt = 0;
      int c64_moved = 0;
      bit got_done = 1'b0;
      FixC64 = 1'b1; Autoload = 1'b1; REUBase = 19'h7FFF0; LenBase = 16'd0;
      Cmd = 2'b00; BA = 1'b1;
      @(negedge PHI2);
      Execute = 1'b1;
      @(negedge PHI2);
      Execute = 1'b0;
      for (int c = 0; c < 70000 && !got_done; c++) begin
        #1;
        if (RAMWE) wr_cnt++;
        if (C64A != 16'hC000) c64_moved++;
        if (Done) got_done = 1'b1;
        else @(negedge PHI2);
      end
      chk("big.timeout", 32'(got_done), 32'd1);
      chk("big.wr_cnt", 32'(wr_cnt), 32'd65536);
      chk("big.c64_moved", 32'(c64_moved), 32'd0);
      chk("big.eob", 32'(EOB), 32'd1);
      chk("big.fault", 32'(Fault), 32'd0);
      chk("big.reua_final", 32'(REUA), 32'h0FFF0);
      @(negedge PHI2);
      #1;
      chk("big.reua_reload", 32'(REUA), 32'h7FFF0);
      chk("big.c64a_reload", 32'(C64A), 32'hC000);
      chk("big.busy", 32'(Busy), 32'd0);
      chk("big.done_clr", 32'(Done), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
